// File: rtl/dm_pkg.sv
// Shared definitions for the data-memory access controller: MIPS load/store
// opcodes, access-size encoding, FSM state codes and opcode decode helpers.
package dm_pkg;

    localparam logic [5:0] OP_LB  = 6'b100000;
    localparam logic [5:0] OP_LH  = 6'b100001;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_LBU = 6'b100100;
    localparam logic [5:0] OP_LHU = 6'b100101;
    localparam logic [5:0] OP_SB  = 6'b101000;
    localparam logic [5:0] OP_SH  = 6'b101001;
    localparam logic [5:0] OP_SW  = 6'b101011;

    // Size is encoded directly as a byte count so it can feed shifts and adds.
    typedef enum logic [2:0] {
        SIZE_NONE = 3'd0,
        SIZE_B    = 3'd1,
        SIZE_H    = 3'd2,
        SIZE_W    = 3'd4
    } size_e;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_BEAT0  = 3'd1;
    localparam logic [2:0] ST_RWAIT0 = 3'd2;
    localparam logic [2:0] ST_BEAT1  = 3'd3;
    localparam logic [2:0] ST_RWAIT1 = 3'd4;
    localparam logic [2:0] ST_RESP   = 3'd5;

    function automatic logic op_is_load(input logic [5:0] op);
        return (op == OP_LB) || (op == OP_LH) || (op == OP_LW) ||
               (op == OP_LBU) || (op == OP_LHU);
    endfunction

    function automatic logic op_is_store(input logic [5:0] op);
        return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    endfunction

    function automatic size_e op_size(input logic [5:0] op);
        case (op)
            OP_LB, OP_LBU, OP_SB: return SIZE_B;
            OP_LH, OP_LHU, OP_SH: return SIZE_H;
            OP_LW, OP_SW:         return SIZE_W;
            default:              return SIZE_NONE;
        endcase
    endfunction

    function automatic logic op_signed(input logic [5:0] op);
        return (op == OP_LB) || (op == OP_LH) || (op == OP_LW);
    endfunction

endpackage

// File: rtl/dm_lane_align.sv
// Combinational byte-enable and write-data lane placement for one memory beat.
// The access is shifted into a double-width window; beat 0 takes the low half.
module dm_lane_align #(
    parameter int DATA_W = 32
) (
    input  logic [2:0]                   size,
    input  logic [$clog2(DATA_W/8)-1:0]  off,
    input  logic                         beat,
    input  logic [DATA_W-1:0]            data,
    output logic [DATA_W/8-1:0]          be,
    output logic [DATA_W-1:0]            wdata
);
    localparam int LANES = DATA_W / 8;

    logic [2*LANES-1:0]  be_full;
    logic [2*DATA_W-1:0] data_full;

    always_comb begin
        be_full   = ((2*LANES)'(1) << size) - (2*LANES)'(1);
        be_full   = be_full << off;
        data_full = {{DATA_W{1'b0}}, data} << {off, 3'b000};
        if (beat) begin
            be    = be_full[2*LANES-1:LANES];
            wdata = data_full[2*DATA_W-1:DATA_W];
        end else begin
            be    = be_full[LANES-1:0];
            wdata = data_full[DATA_W-1:0];
        end
    end

endmodule

// File: rtl/dm_access_ctrl.sv
// M-stage data-memory access controller: one load/store per handshake.
// Define MISALIGN_SPLIT_EN to split lane-crossing accesses into two beats.
module dm_access_ctrl
    import dm_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [5:0]          req_op,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    output logic                mem_valid,
    input  logic                mem_ready,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W/8-1:0] mem_be,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic                mem_rvalid,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                rsp_valid,
    output logic [DATA_W-1:0]   rsp_data,
    output logic                rsp_err
);
    localparam int LANES = DATA_W / 8;
    localparam int OFF_W = $clog2(LANES);

    logic [2:0]        state;
    logic [2:0]        size_q;
    logic [OFF_W-1:0]  off_q;
    logic              sgn_q;
    logic              split_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_lo_q;

    logic              idle;
    logic              req_is_load;
    logic              req_is_store;
    logic [2:0]        req_size;
    logic [OFF_W-1:0]  req_off;
    logic              req_split;
    logic              req_misalign;

    logic [2:0]        al_size;
    logic [OFF_W-1:0]  al_off;
    logic [DATA_W-1:0] al_data;
    logic [LANES-1:0]  al_be;
    logic [DATA_W-1:0] al_wdata;

    assign idle         = (state == ST_IDLE);
    assign req_ready    = idle;
    assign req_is_load  = op_is_load(req_op);
    assign req_is_store = op_is_store(req_op);
    assign req_size     = op_size(req_op);
    assign req_off      = req_addr[OFF_W-1:0];

`ifdef MISALIGN_SPLIT_EN
    logic [OFF_W+1:0] req_end;
    assign req_end      = (OFF_W+2)'(req_off) + (OFF_W+2)'(req_size) - (OFF_W+2)'(1);
    assign req_split    = (req_end >= (OFF_W+2)'(LANES));
    assign req_misalign = 1'b0;
`else
    logic [2:0] size_mask;
    assign size_mask    = req_size - 3'd1;
    assign req_split    = 1'b0;
    assign req_misalign = ((req_addr[2:0] & size_mask) != 3'd0);
`endif

    // The aligner sees the live request in IDLE (first beat) and the latched
    // request afterwards, where it only ever produces the second beat.
    assign al_size = idle ? req_size  : size_q;
    assign al_off  = idle ? req_off   : off_q;
    assign al_data = idle ? req_wdata : wdata_q;

    dm_lane_align #(.DATA_W(DATA_W)) u_align (
        .size  (al_size),
        .off   (al_off),
        .beat  (!idle),
        .data  (al_data),
        .be    (al_be),
        .wdata (al_wdata)
    );

    function automatic logic [DATA_W-1:0] load_result(
        input logic [2*DATA_W-1:0] raw,
        input logic [OFF_W-1:0]    off,
        input logic [2:0]          size,
        input logic                sgn
    );
        logic [2*DATA_W-1:0] sh;
        logic [DATA_W-1:0]   v;
        logic                sbit;
        sh = raw >> {off, 3'b000};
        v  = sh[DATA_W-1:0];
        case (size)
            3'd1:    sbit = v[7];
            3'd2:    sbit = v[15];
            default: sbit = v[31];
        endcase
        for (int i = 0; i < DATA_W; i++) begin
            if (i >= 8 * int'(size)) v[i] = sgn & sbit;
        end
        return v;
    endfunction

    // Main sequencer; every memory and response output is a register here.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            size_q     <= 3'd0;
            off_q      <= '0;
            sgn_q      <= 1'b0;
            split_q    <= 1'b0;
            wdata_q    <= '0;
            rdata_lo_q <= '0;
            mem_valid  <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_be     <= '0;
            mem_wdata  <= '0;
            rsp_valid  <= 1'b0;
            rsp_data   <= '0;
            rsp_err    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        size_q  <= req_size;
                        off_q   <= req_off;
                        sgn_q   <= op_signed(req_op);
                        split_q <= req_split;
                        wdata_q <= req_wdata;
                        if (!(req_is_load || req_is_store)) begin
                            state     <= ST_RESP;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b0;
                            rsp_data  <= '0;
                        end else begin
                            state <= ST_BEAT0;
                            if (!req_misalign) begin
                                mem_valid <= 1'b1;
                                mem_we    <= req_is_store;
                                mem_addr  <= {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                                mem_be    <= al_be;
                                mem_wdata <= al_wdata;
                            end
                        end
                    end
                end
                ST_BEAT0: begin
                    // No beat was launched: this is a rejected misaligned access.
                    if (!mem_valid) begin
                        state     <= ST_RESP;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                        rsp_data  <= '0;
                    end else if (mem_ready) begin
                        mem_valid <= 1'b0;
                        if (!mem_we) begin
                            state <= ST_RWAIT0;
                        end else if (split_q) begin
                            state     <= ST_BEAT1;
                            mem_valid <= 1'b1;
                            mem_addr  <= mem_addr + ADDR_W'(LANES);
                            mem_be    <= al_be;
                            mem_wdata <= al_wdata;
                        end else begin
                            state     <= ST_RESP;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b0;
                            rsp_data  <= '0;
                        end
                    end
                end
                ST_RWAIT0: begin
                    if (mem_rvalid) begin
                        rdata_lo_q <= mem_rdata;
                        if (split_q) begin
                            state     <= ST_BEAT1;
                            mem_valid <= 1'b1;
                            mem_addr  <= mem_addr + ADDR_W'(LANES);
                            mem_be    <= al_be;
                            mem_wdata <= al_wdata;
                        end else begin
                            state     <= ST_RESP;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b0;
                            rsp_data  <= load_result({{DATA_W{1'b0}}, mem_rdata}, off_q, size_q, sgn_q);
                        end
                    end
                end
                ST_BEAT1: begin
                    if (mem_ready) begin
                        mem_valid <= 1'b0;
                        if (mem_we) begin
                            state     <= ST_RESP;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b0;
                            rsp_data  <= '0;
                        end else begin
                            state <= ST_RWAIT1;
                        end
                    end
                end
                ST_RWAIT1: begin
                    if (mem_rvalid) begin
                        state     <= ST_RESP;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b0;
                        rsp_data  <= load_result({mem_rdata, rdata_lo_q}, off_q, size_q, sgn_q);
                    end
                end
                ST_RESP: begin
                    state     <= ST_IDLE;
                    rsp_valid <= 1'b0;
                end
                default: begin
                    state     <= ST_IDLE;
                    mem_valid <= 1'b0;
                    rsp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dm_access_ctrl.sv
// Directed bench for dm_access_ctrl: a 32-bit and a 64-bit instance share
// clock and reset. Split-access scenarios are exercised when MISALIGN_SPLIT_EN is set.
module tb_dm_access_ctrl;
    import dm_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_n;

    logic        req_valid, req_ready;
    logic [5:0]  req_op;
    logic [31:0] req_addr, req_wdata;
    logic        mem_valid, mem_ready, mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        rsp_err;

    logic        w_req_valid, w_req_ready;
    logic [5:0]  w_req_op;
    logic [31:0] w_req_addr;
    logic [63:0] w_req_wdata;
    logic        w_mem_valid, w_mem_ready, w_mem_we;
    logic [31:0] w_mem_addr;
    logic [7:0]  w_mem_be;
    logic [63:0] w_mem_wdata;
    logic        w_mem_rvalid;
    logic [63:0] w_mem_rdata;
    logic        w_rsp_valid;
    logic [63:0] w_rsp_data;
    logic        w_rsp_err;

    int checks   = 0;
    int failures = 0;

    dm_access_ctrl #(.DATA_W(32), .ADDR_W(32)) dut32 (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err)
    );

    dm_access_ctrl #(.DATA_W(64), .ADDR_W(32)) dut64 (
        .clk(clk), .reset_n(reset_n),
        .req_valid(w_req_valid), .req_ready(w_req_ready), .req_op(w_req_op),
        .req_addr(w_req_addr), .req_wdata(w_req_wdata),
        .mem_valid(w_mem_valid), .mem_ready(w_mem_ready), .mem_we(w_mem_we),
        .mem_addr(w_mem_addr), .mem_be(w_mem_be), .mem_wdata(w_mem_wdata),
        .mem_rvalid(w_mem_rvalid), .mem_rdata(w_mem_rdata),
        .rsp_valid(w_rsp_valid), .rsp_data(w_rsp_data), .rsp_err(w_rsp_err)
    );

    task automatic issue32(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] data);
        req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = data;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic issue64(input logic [5:0] op, input logic [31:0] addr, input logic [63:0] data);
        w_req_valid = 1'b1; w_req_op = op; w_req_addr = addr; w_req_wdata = data;
        @(negedge clk);
        w_req_valid = 1'b0;
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (req_ready !== 1'b1) begin failures++; $display("[TB] FAIL reset_req_ready got=%0h exp=1", req_ready); end
        checks++; if ({mem_valid, mem_we, rsp_valid, rsp_err} !== 4'b0000) begin failures++; $display("[TB] FAIL reset_flags got=%b exp=0000", {mem_valid, mem_we, rsp_valid, rsp_err}); end
        checks++; if ({mem_addr, mem_be, mem_wdata, rsp_data} !== 100'd0) begin failures++; $display("[TB] FAIL reset_buses got=%h exp=0", {mem_addr, mem_be, mem_wdata, rsp_data}); end
        checks++; if ({w_req_ready, w_mem_valid, w_rsp_valid, w_mem_be} !== 11'b100_00000000) begin failures++; $display("[TB] FAIL reset64_flags got=%b exp=10000000000", {w_req_ready, w_mem_valid, w_rsp_valid, w_mem_be}); end
        reset_n = 1'b1;
        @(negedge clk);
        checks++; if (req_ready !== 1'b1) begin failures++; $display("[TB] FAIL reset_release_ready got=%0h exp=1", req_ready); end
    endtask

    task automatic test_store_byte;
        mem_ready = 1'b1;
        issue32(OP_SB, 32'h13, 32'hAB);
        checks++; if ({mem_valid, mem_we} !== 2'b11) begin failures++; $display("[TB] FAIL sb_beat_flags got=%b exp=11", {mem_valid, mem_we}); end
        checks++; if (mem_addr !== 32'h10) begin failures++; $display("[TB] FAIL sb_addr got=%h exp=00000010", mem_addr); end
        checks++; if (mem_be !== 4'b1000) begin failures++; $display("[TB] FAIL sb_be got=%b exp=1000", mem_be); end
        checks++; if (mem_wdata !== 32'hAB000000) begin failures++; $display("[TB] FAIL sb_wdata got=%h exp=ab000000", mem_wdata); end
        checks++; if ({req_ready, rsp_valid} !== 2'b00) begin failures++; $display("[TB] FAIL sb_busy got=%b exp=00", {req_ready, rsp_valid}); end
        @(negedge clk);
        checks++; if ({rsp_valid, rsp_err, mem_valid} !== 3'b100) begin failures++; $display("[TB] FAIL sb_rsp got=%b exp=100", {rsp_valid, rsp_err, mem_valid}); end
        checks++; if (rsp_data !== 32'h0) begin failures++; $display("[TB] FAIL sb_rsp_data got=%h exp=00000000", rsp_data); end
        @(negedge clk);
        checks++; if ({rsp_valid, req_ready} !== 2'b01) begin failures++; $display("[TB] FAIL sb_done got=%b exp=01", {rsp_valid, req_ready}); end
    endtask

    task automatic test_load_half;
        logic [5:0]  ops [2];
        logic [31:0] exp [2];
        ops[0] = OP_LH;  exp[0] = 32'hFFFF80FF;
        ops[1] = OP_LHU; exp[1] = 32'h000080FF;
        mem_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            issue32(ops[k], 32'h22, 32'h0);
            checks++; if ({mem_valid, mem_we, mem_be} !== 6'b10_1100) begin failures++; $display("[TB] FAIL lh%0d_beat got=%b exp=101100", k, {mem_valid, mem_we, mem_be}); end
            checks++; if (mem_addr !== 32'h20) begin failures++; $display("[TB] FAIL lh%0d_addr got=%h exp=00000020", k, mem_addr); end
            @(negedge clk);
            checks++; if (rsp_valid !== 1'b0) begin failures++; $display("[TB] FAIL lh%0d_early_rsp got=%0h exp=0", k, rsp_valid); end
            mem_rvalid = 1'b1; mem_rdata = 32'h80FF0000;
            @(negedge clk);
            mem_rvalid = 1'b0;
            checks++; if ({rsp_valid, rsp_err} !== 2'b10) begin failures++; $display("[TB] FAIL lh%0d_rsp got=%b exp=10", k, {rsp_valid, rsp_err}); end
            checks++; if (rsp_data !== exp[k]) begin failures++; $display("[TB] FAIL lh%0d_data got=%h exp=%h", k, rsp_data, exp[k]); end
            @(negedge clk);
        end
    endtask

    task automatic test_load_word_64;
        w_mem_ready = 1'b1;
        issue64(OP_LW, 32'hFFFFFFFC, 64'h0);
        checks++; if ({w_mem_valid, w_mem_be} !== 9'b1_11110000) begin failures++; $display("[TB] FAIL lw64_beat got=%b exp=111110000", {w_mem_valid, w_mem_be}); end
        checks++; if (w_mem_addr !== 32'hFFFFFFF8) begin failures++; $display("[TB] FAIL lw64_addr got=%h exp=fffffff8", w_mem_addr); end
        @(negedge clk);
        w_mem_rvalid = 1'b1; w_mem_rdata = 64'h84332211_00000000;
        @(negedge clk);
        w_mem_rvalid = 1'b0;
        checks++; if (w_rsp_valid !== 1'b1) begin failures++; $display("[TB] FAIL lw64_rsp_valid got=%0h exp=1", w_rsp_valid); end
        checks++; if (w_rsp_data !== 64'hFFFFFFFF_84332211) begin failures++; $display("[TB] FAIL lw64_data got=%h exp=ffffffff84332211", w_rsp_data); end
        @(negedge clk);
    endtask

    task automatic test_store_half_64;
        w_mem_ready = 1'b1;
        issue64(OP_SH, 32'h6, 64'h1234);
        checks++; if ({w_mem_valid, w_mem_we, w_mem_be} !== 10'b11_11000000) begin failures++; $display("[TB] FAIL sh64_beat got=%b exp=1111000000", {w_mem_valid, w_mem_we, w_mem_be}); end
        checks++; if (w_mem_addr !== 32'h0) begin failures++; $display("[TB] FAIL sh64_addr got=%h exp=00000000", w_mem_addr); end
        checks++; if (w_mem_wdata !== 64'h1234_0000_0000_0000) begin failures++; $display("[TB] FAIL sh64_wdata got=%h exp=1234000000000000", w_mem_wdata); end
        @(negedge clk);
        checks++; if ({w_rsp_valid, w_rsp_err} !== 2'b10) begin failures++; $display("[TB] FAIL sh64_rsp got=%b exp=10", {w_rsp_valid, w_rsp_err}); end
        @(negedge clk);
    endtask

    task automatic test_stall;
        mem_ready = 1'b0;
        issue32(OP_SW, 32'h40, 32'h11223344);
        for (int c = 0; c < 5; c++) begin
            checks++;
            if ({mem_valid, mem_we, mem_be, req_ready} !== 7'b11_1111_0 || mem_addr !== 32'h40 || mem_wdata !== 32'h11223344) begin
                failures++;
                $display("[TB] FAIL stall_c%0d got=%b/%h/%h exp=1111110/00000040/11223344", c, {mem_valid, mem_we, mem_be, req_ready}, mem_addr, mem_wdata);
            end
            if (c < 4) @(negedge clk);
        end
        mem_ready = 1'b1;
        @(negedge clk);
        checks++; if ({rsp_valid, mem_valid} !== 2'b10) begin failures++; $display("[TB] FAIL stall_release got=%b exp=10", {rsp_valid, mem_valid}); end
        @(negedge clk);
    endtask

    task automatic test_reset_in_rwait;
        mem_ready = 1'b1;
        issue32(OP_LW, 32'h50, 32'h0);
        checks++; if (mem_valid !== 1'b1) begin failures++; $display("[TB] FAIL rstw_beat got=%0h exp=1", mem_valid); end
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        mem_rvalid = 1'b1; mem_rdata = 32'hDEADBEEF;
        checks++; if ({req_ready, mem_valid, rsp_valid} !== 3'b100) begin failures++; $display("[TB] FAIL rstw_idle got=%b exp=100", {req_ready, mem_valid, rsp_valid}); end
        @(negedge clk);
        mem_rvalid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            checks++; if (rsp_valid !== 1'b0) begin failures++; $display("[TB] FAIL rstw_stale_rsp_c%0d got=%0h exp=0", c, rsp_valid); end
            @(negedge clk);
        end
    endtask

    task automatic test_illegal_op;
        logic seen_rsp, seen_beat, got_err;
        logic [31:0] got_data;
        seen_rsp = 1'b0; seen_beat = 1'b0; got_err = 1'b0; got_data = '0;
        issue32(6'b001000, 32'h13, 32'h5A5A5A5A);
        for (int c = 0; c < 4 && !seen_rsp; c++) begin
            if (mem_valid) seen_beat = 1'b1;
            if (rsp_valid) begin
                seen_rsp = 1'b1; got_err = rsp_err; got_data = rsp_data;
            end else begin
                @(negedge clk);
            end
        end
        checks++; if (seen_rsp !== 1'b1) begin failures++; $display("[TB] FAIL illop_rsp_timeout got=%0h exp=1", seen_rsp); end
        checks++; if (seen_beat !== 1'b0) begin failures++; $display("[TB] FAIL illop_beat got=%0h exp=0", seen_beat); end
        checks++; if ({got_err, got_data} !== 33'd0) begin failures++; $display("[TB] FAIL illop_rsp got=%0h/%h exp=0/00000000", got_err, got_data); end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_back_to_back;
        logic [5:0]  ops [2];
        logic [31:0] exp [2];
        ops[0] = OP_LBU; exp[0] = 32'h00000085;
        ops[1] = OP_LB;  exp[1] = 32'hFFFFFF85;
        mem_ready = 1'b1;
        issue32(OP_SW, 32'h60, 32'hCAFEF00D);
        @(negedge clk);
        checks++; if ({rsp_valid, req_ready} !== 2'b10) begin failures++; $display("[TB] FAIL b2b_rsp_cycle got=%b exp=10", {rsp_valid, req_ready}); end
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            checks++; if (req_ready !== 1'b1) begin failures++; $display("[TB] FAIL b2b%0d_ready got=%0h exp=1", k, req_ready); end
            issue32(ops[k], 32'h61, 32'h0);
            checks++; if ({mem_valid, mem_we, mem_be} !== 6'b10_0010 || mem_addr !== 32'h60) begin failures++; $display("[TB] FAIL b2b%0d_beat got=%b/%h exp=100010/00000060", k, {mem_valid, mem_we, mem_be}, mem_addr); end
            @(negedge clk);
            mem_rvalid = 1'b1; mem_rdata = 32'h00008500;
            @(negedge clk);
            mem_rvalid = 1'b0;
            checks++; if (rsp_valid !== 1'b1 || rsp_data !== exp[k]) begin failures++; $display("[TB] FAIL b2b%0d_rsp got=%0h/%h exp=1/%h", k, rsp_valid, rsp_data, exp[k]); end
            @(negedge clk);
        end
    endtask

`ifdef MISALIGN_SPLIT_EN
    task automatic test_misalign;
        mem_ready = 1'b1;
        issue32(OP_SW, 32'h1001, 32'hDDCCBBAA);
        checks++; if ({mem_valid, mem_we, mem_be} !== 6'b11_1110 || mem_addr !== 32'h1000 || mem_wdata !== 32'hCCBBAA00) begin failures++; $display("[TB] FAIL split_sw_beat0 got=%b/%h/%h exp=111110/00001000/ccbbaa00", {mem_valid, mem_we, mem_be}, mem_addr, mem_wdata); end
        @(negedge clk);
        checks++; if ({mem_valid, mem_we, mem_be} !== 6'b11_0001 || mem_addr !== 32'h1004 || mem_wdata !== 32'h000000DD) begin failures++; $display("[TB] FAIL split_sw_beat1 got=%b/%h/%h exp=110001/00001004/000000dd", {mem_valid, mem_we, mem_be}, mem_addr, mem_wdata); end
        @(negedge clk);
        checks++; if ({rsp_valid, rsp_err} !== 2'b10) begin failures++; $display("[TB] FAIL split_sw_rsp got=%b exp=10", {rsp_valid, rsp_err}); end
        @(negedge clk);
        issue32(OP_LW, 32'hFFFFFFFE, 32'h0);
        checks++; if ({mem_valid, mem_be} !== 5'b1_1100 || mem_addr !== 32'hFFFFFFFC) begin failures++; $display("[TB] FAIL split_lw_beat0 got=%b/%h exp=11100/fffffffc", {mem_valid, mem_be}, mem_addr); end
        @(negedge clk);
        mem_rvalid = 1'b1; mem_rdata = 32'h22110000;
        @(negedge clk);
        mem_rvalid = 1'b0;
        checks++; if ({mem_valid, mem_we, mem_be} !== 6'b10_0011 || mem_addr !== 32'h0) begin failures++; $display("[TB] FAIL split_lw_beat1 got=%b/%h exp=100011/00000000", {mem_valid, mem_we, mem_be}, mem_addr); end
        @(negedge clk);
        mem_rvalid = 1'b1; mem_rdata = 32'h00008433;
        @(negedge clk);
        mem_rvalid = 1'b0;
        checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_data !== 32'h84332211) begin failures++; $display("[TB] FAIL split_lw_rsp got=%0h/%0h/%h exp=1/0/84332211", rsp_valid, rsp_err, rsp_data); end
        @(negedge clk);
        w_mem_ready = 1'b1;
        issue64(OP_LW, 32'hFFFFFFFE, 64'h0);
        checks++; if (w_mem_be !== 8'b11000000 || w_mem_addr !== 32'hFFFFFFF8) begin failures++; $display("[TB] FAIL split_lw64_beat0 got=%b/%h exp=11000000/fffffff8", w_mem_be, w_mem_addr); end
        @(negedge clk);
        w_mem_rvalid = 1'b1; w_mem_rdata = 64'h2211_0000_0000_0000;
        @(negedge clk);
        w_mem_rvalid = 1'b0;
        checks++; if (w_mem_be !== 8'b00000011 || w_mem_addr !== 32'h0) begin failures++; $display("[TB] FAIL split_lw64_beat1 got=%b/%h exp=00000011/00000000", w_mem_be, w_mem_addr); end
        @(negedge clk);
        w_mem_rvalid = 1'b1; w_mem_rdata = 64'h8433;
        @(negedge clk);
        w_mem_rvalid = 1'b0;
        checks++; if (w_rsp_valid !== 1'b1 || w_rsp_data !== 64'hFFFFFFFF_84332211) begin failures++; $display("[TB] FAIL split_lw64_rsp got=%0h/%h exp=1/ffffffff84332211", w_rsp_valid, w_rsp_data); end
        @(negedge clk);
    endtask
`else
    task automatic test_misalign;
        logic [5:0]  ops   [2];
        logic [31:0] addrs [2];
        ops[0] = OP_SW; addrs[0] = 32'h1001;
        ops[1] = OP_LH; addrs[1] = 32'h1001;
        mem_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            issue32(ops[k], addrs[k], 32'hDDCCBBAA);
            checks++; if ({mem_valid, rsp_valid} !== 2'b00) begin failures++; $display("[TB] FAIL mis%0d_gap got=%b exp=00", k, {mem_valid, rsp_valid}); end
            @(negedge clk);
            checks++; if ({rsp_valid, rsp_err, mem_valid} !== 3'b110) begin failures++; $display("[TB] FAIL mis%0d_rsp got=%b exp=110", k, {rsp_valid, rsp_err, mem_valid}); end
            checks++; if (rsp_data !== 32'h0) begin failures++; $display("[TB] FAIL mis%0d_data got=%h exp=00000000", k, rsp_data); end
            @(negedge clk);
        end
    endtask
`endif

    initial begin
        reset_n = 1'b0;
        req_valid = 1'b0; req_op = '0; req_addr = '0; req_wdata = '0;
        mem_ready = 1'b1; mem_rvalid = 1'b0; mem_rdata = '0;
        w_req_valid = 1'b0; w_req_op = '0; w_req_addr = '0; w_req_wdata = '0;
        w_mem_ready = 1'b1; w_mem_rvalid = 1'b0; w_mem_rdata = '0;
        @(negedge clk);
        test_reset;
        test_store_byte;
        test_load_half;
        test_misalign;
        test_stall;
        test_reset_in_rwait;
        test_illegal_op;
        test_back_to_back;
        test_load_word_64;
        test_store_half_64;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog got=timeout exp=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
